modexp_ctrl: RTL and testbench
==============================

MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 2048: operand, modulus and exponent width.
REQ-002 SHALL have parameter EWIDTH, default 12: width of e_size; holds 0..NBITS.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_p  input  1  one-cycle request pulse; sampled only in IDLE.
REQ-006 SHALL have port base  input  NBITS  base x, already reduced (x < m).
REQ-007 SHALL have port exp  input  NBITS  exponent e.
REQ-008 SHALL have port e_size  input  EWIDTH  number of exponent bits processed, MSB = exp[e_size-1].
REQ-009 SHALL have port m  input  NBITS  odd modulus.
REQ-010 SHALL have port m_size  input  11  modulus bit count; R = 2^m_size.
REQ-011 SHALL have port r2  input  NBITS  R^2 mod m.
REQ-012 SHALL have port busy  output  1  high from the cycle after an accepted start_p until done_p.
REQ-013 SHALL have port done_p  output  1  one-cycle completion pulse.
REQ-014 SHALL have port y  output  NBITS  result x^e mod m; held until the next accepted start.
REQ-015 SHALL have port mm_enable_p  output  1  one-cycle pulse to the Montgomery multiplier.
REQ-016 SHALL have ports mm_a and mm_b  output  NBITS  multiplier operands, stable from mm_enable_p until mm_done_p.
REQ-017 SHALL have ports mm_m (NBITS), mm_m_size (11) and mm_r_red (NBITS)  output  registered copies of m, m_size and r2.
REQ-018 SHALL have port mm_y  input  NBITS  multiplier result, valid in the mm_done_p cycle.
REQ-019 SHALL have port mm_done_p  input  1  multiplier completion pulse.

Function
REQ-020 SHALL latch base, exp, e_size (values above NBITS clamped to NBITS), m, m_size and r2 on start_p in IDLE; start_p in any other state SHALL be ignored.
REQ-021 SHALL implement states IDLE, TOMONT_X, TOMONT_1, SQR, MUL, FROMMONT, DONE, each multiply state split into an issue phase and a wait phase.
REQ-022 Issue phase: mm_enable_p high for exactly one cycle with mm_a/mm_b driven; wait phase: hold operands and capture mm_y on the mm_done_p edge.
REQ-023 Next mm_enable_p SHALL occur the cycle after the capturing mm_done_p; for multiplier latency L, each multiply costs L+1 cycles.
REQ-024 mm_done_p while no multiply is outstanding SHALL be ignored.
REQ-025 TOMONT_X: xm = MM(x, r2); TOMONT_1: acc = MM(1, r2).
REQ-026 Loop over bit i from e_size-1 down to 0: SQR acc = MM(acc, acc); then if exp[i]=1, MUL acc = MM(acc, xm).
REQ-027 After bit 0, or directly after TOMONT_1 when e_size=0, FROMMONT: y = MM(acc, 1), giving y = 1 for e_size=0.
REQ-028 DONE SHALL last one cycle: done_p=1, busy=0 in that cycle, y updated, return to IDLE; start_p in DONE SHALL be ignored.
REQ-029 Bit index counter SHALL be EWIDTH wide and SHALL NOT wrap below 0.

Reset
REQ-030 On rst: state=IDLE, busy=0, done_p=0, mm_enable_p=0, y=0, mm_a=mm_b=0, bit counter=0.
REQ-031 rst mid-operation SHALL abandon the exponentiation; a later stray mm_done_p SHALL be ignored.

Configuration
REQ-032 Macro MODEXP_CONST_TIME_EN defined: MUL SHALL execute for every bit, with acc written only when exp[i]=1; multiply count = 3 + 2*e_size.
REQ-033 MODEXP_CONST_TIME_EN undefined: MUL SHALL be skipped when exp[i]=0; multiply count = 3 + e_size + popcount(exp[e_size-1:0]).

Verification
REQ-034 Bench SHALL use a golden multiplier model with fixed L=10 and cover:
- base=5792, exp=3, e_size=2, m=72639, m_size=17 -> y=60038, 7 mm_enable_p pulses, done_p once.
- base=5792, exp=4, e_size=3 -> y=5792^4 mod 72639; 7 pulses without MODEXP_CONST_TIME_EN, 9 with.
- e_size=0 -> y=1 after 3 multiplies; base=5792, exp=1, e_size=1 -> y=5792.
- start_p re-pulsed while busy -> ignored, result unchanged, no extra mm_enable_p.
- rst asserted during SQR, then stray mm_done_p -> IDLE, busy=0, no done_p, next run correct.

Source files
------------

// File: rtl/modexp_ctrl.sv
// Modular exponentiation sequencer driving an external Montgomery multiplier (MSB-first square-and-multiply).
// Latency: (3 + squares + multiplies) * (L+1) + 2 cycles for multiplier latency L; one multiply outstanding at a time.
// Backpressure: none; start_p is accepted only in IDLE, mm_done_p only while a multiply is outstanding. Option: MODEXP_CONST_TIME_EN.
module modexp_ctrl #(
    parameter int NBITS  = 2048,
    parameter int EWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_p,
    input  logic [NBITS-1:0]  base,
    input  logic [NBITS-1:0]  exp,
    input  logic [EWIDTH-1:0] e_size,
    input  logic [NBITS-1:0]  m,
    input  logic [10:0]       m_size,
    input  logic [NBITS-1:0]  r2,
    output logic              busy,
    output logic              done_p,
    output logic [NBITS-1:0]  y,
    output logic              mm_enable_p,
    output logic [NBITS-1:0]  mm_a,
    output logic [NBITS-1:0]  mm_b,
    output logic [NBITS-1:0]  mm_m,
    output logic [10:0]       mm_m_size,
    output logic [NBITS-1:0]  mm_r_red,
    input  logic [NBITS-1:0]  mm_y,
    input  logic              mm_done_p
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TOMONT_X = 3'd1;
    localparam logic [2:0] S_TOMONT_1 = 3'd2;
    localparam logic [2:0] S_SQR      = 3'd3;
    localparam logic [2:0] S_MUL      = 3'd4;
    localparam logic [2:0] S_FROMMONT = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam int                IDXW = $clog2(NBITS);
    localparam logic [NBITS-1:0]  ONE  = NBITS'(1);
    localparam logic [EWIDTH-1:0] NB_E = EWIDTH'(NBITS);

    logic [2:0]        state;
    logic              wait_ph;
    logic [NBITS-1:0]  x_r;
    logic [NBITS-1:0]  e_r;
    logic [EWIDTH-1:0] esz_r;
    logic [NBITS-1:0]  xm;
    logic [NBITS-1:0]  acc;
    logic [EWIDTH-1:0] bit_idx;

    logic is_mult;
    logic cur_bit;
    logic last_bit;
    logic mul_needed;
    logic acc_mul_wr;

    always_comb begin
        is_mult  = (state == S_TOMONT_X) || (state == S_TOMONT_1) || (state == S_SQR) ||
                   (state == S_MUL) || (state == S_FROMMONT);
        cur_bit  = e_r[bit_idx[IDXW-1:0]];
        last_bit = (bit_idx == '0);
`ifdef MODEXP_CONST_TIME_EN
        // Every bit pays for a multiply; only set bits keep its product.
        mul_needed = 1'b1;
        acc_mul_wr = cur_bit;
`else
        mul_needed = cur_bit;
        acc_mul_wr = 1'b1;
`endif
    end

    always_comb begin
        busy        = (state != S_IDLE) && (state != S_DONE);
        done_p      = (state == S_DONE);
        mm_enable_p = is_mult && !wait_ph;
        mm_a        = '0;
        mm_b        = '0;
        case (state)
            S_TOMONT_X: begin mm_a = x_r; mm_b = mm_r_red; end
            S_TOMONT_1: begin mm_a = ONE; mm_b = mm_r_red; end
            S_SQR:      begin mm_a = acc; mm_b = acc;      end
            S_MUL:      begin mm_a = acc; mm_b = xm;       end
            S_FROMMONT: begin mm_a = acc; mm_b = ONE;      end
            default:    begin mm_a = '0;  mm_b = '0;       end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wait_ph <= 1'b0;
            y       <= '0;
            bit_idx <= '0;
            acc     <= '0;
            xm      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_p) begin
                        x_r       <= base;
                        e_r       <= exp;
                        esz_r     <= (e_size > NB_E) ? NB_E : e_size;
                        mm_m      <= m;
                        mm_m_size <= m_size;
                        mm_r_red  <= r2;
                        wait_ph   <= 1'b0;
                        state     <= S_TOMONT_X;
                    end
                end
                S_DONE: state <= S_IDLE;
                S_TOMONT_X, S_TOMONT_1, S_SQR, S_MUL, S_FROMMONT: begin
                    if (!wait_ph) begin
                        wait_ph <= 1'b1;
                    end else if (mm_done_p) begin
                        wait_ph <= 1'b0;
                        case (state)
                            S_TOMONT_X: begin
                                xm    <= mm_y;
                                state <= S_TOMONT_1;
                            end
                            S_TOMONT_1: begin
                                acc <= mm_y;
                                if (esz_r == '0) begin
                                    state <= S_FROMMONT;
                                end else begin
                                    bit_idx <= esz_r - EWIDTH'(1);
                                    state   <= S_SQR;
                                end
                            end
                            S_SQR: begin
                                acc <= mm_y;
                                if (mul_needed) begin
                                    state <= S_MUL;
                                end else if (last_bit) begin
                                    state <= S_FROMMONT;
                                end else begin
                                    bit_idx <= bit_idx - EWIDTH'(1);
                                    state   <= S_SQR;
                                end
                            end
                            S_MUL: begin
                                if (acc_mul_wr) acc <= mm_y;
                                if (last_bit) begin
                                    state <= S_FROMMONT;
                                end else begin
                                    bit_idx <= bit_idx - EWIDTH'(1);
                                    state   <= S_SQR;
                                end
                            end
                            default: begin
                                y     <= mm_y;
                                state <= S_DONE;
                            end
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: golden Montgomery multiplier (L=10), plain powmod reference, table + random + corner sequences.
module tb_modexp_ctrl;
    localparam int NB = 32;
    localparam int EW = 6;
    localparam int L  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_p = 1'b0;
    logic [NB-1:0] base = '0, exp = '0, m = '0, r2 = '0;
    logic [EW-1:0] e_size = '0;
    logic [10:0]   m_size = '0;
    logic          busy, done_p, mm_enable_p;
    logic [NB-1:0] y, mm_a, mm_b, mm_m, mm_r_red;
    logic [10:0]   mm_m_size;
    logic [NB-1:0] mm_y = '0;
    logic          mm_done_p = 1'b0;

    always #5 clk = ~clk;

    modexp_ctrl #(.NBITS(NB), .EWIDTH(EW)) dut (
        .clk(clk), .rst(rst), .start_p(start_p), .base(base), .exp(exp), .e_size(e_size),
        .m(m), .m_size(m_size), .r2(r2), .busy(busy), .done_p(done_p), .y(y),
        .mm_enable_p(mm_enable_p), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_m_size(mm_m_size), .mm_r_red(mm_r_red), .mm_y(mm_y), .mm_done_p(mm_done_p)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // a*b*2^-msz mod m, by halving modulo an odd m
    function automatic logic [NB-1:0] mont(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                           input logic [NB-1:0] md, input logic [10:0] msz);
        longint unsigned ta, tb, tm, t;
        if (md == '0) return '0;
        ta = a; tb = b; tm = md;
        t = (ta * tb) % tm;
        for (int i = 0; i < int'(msz); i++) t = t[0] ? (t + tm) >> 1 : t >> 1;
        return NB'(t);
    endfunction

    function automatic logic [NB-1:0] r2_of(input logic [NB-1:0] md, input int msz);
        longint unsigned r, tm;
        tm = md;
        r = 1;
        for (int i = 0; i < msz; i++) r = (r * 2) % tm;
        return NB'((r * r) % tm);
    endfunction

    function automatic int eff_size(input int esz);
        return (esz > NB) ? NB : esz;
    endfunction

    function automatic logic [NB-1:0] ref_pow(input logic [NB-1:0] x, input logic [NB-1:0] e,
                                              input int esz, input logic [NB-1:0] md);
        longint unsigned r, tx, tm;
        tm = md; tx = x; r = 1 % tm;
        for (int i = eff_size(esz) - 1; i >= 0; i--) begin
            r = (r * r) % tm;
            if (e[i]) r = (r * tx) % tm;
        end
        return NB'(r);
    endfunction

    function automatic int ref_pulses(input logic [NB-1:0] e, input int esz);
        int n, ones;
        n = eff_size(esz);
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(e[i]);
`ifdef MODEXP_CONST_TIME_EN
        return 3 + 2 * n;
`else
        return 3 + n + ones;
`endif
    endfunction

    // Golden multiplier and observers
    int n_en = 0, n_done = 0, stab_bad = 0, busy_in_done = 0;
    int stray_req = 0, stray_done = 0;
    int cnt = 0;
    bit pending = 1'b0;
    logic [NB-1:0] a_hold, b_hold, res;

    always @(negedge clk) begin
        mm_done_p = 1'b0;
        if (rst) begin
            pending = 1'b0;
            cnt = 0;
        end else begin
            if (stray_done != stray_req) begin
                stray_done = stray_req;
                mm_done_p = 1'b1;
                mm_y = 32'h0001_2345;
            end
            if (pending) begin
                if (mm_a !== a_hold || mm_b !== b_hold) stab_bad++;
                cnt--;
                if (cnt == 0) begin
                    mm_done_p = 1'b1;
                    mm_y = res;
                    pending = 1'b0;
                end
            end
            if (mm_enable_p) begin
                if (pending) stab_bad++;
                pending = 1'b1;
                cnt = L;
                a_hold = mm_a;
                b_hold = mm_b;
                res = mont(mm_a, mm_b, mm_m, mm_m_size);
                n_en++;
            end
            if (done_p) begin
                n_done++;
                if (busy) busy_in_done++;
            end
        end
    end

    task automatic run_op(input logic [NB-1:0] x, input logic [NB-1:0] e, input int esz,
                          input logic [NB-1:0] md, input int msz, input int repulse_at,
                          output logic [NB-1:0] yo, output int pulses, output int dones);
        int en0, d0;
        bit to;
        en0 = n_en;
        d0 = n_done;
        @(negedge clk);
        base = x; exp = e; e_size = EW'(esz); m = md; m_size = 11'(msz); r2 = r2_of(md, msz);
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        chk("busy_after_start", busy, 1);
        base = ~x; exp = ~e; e_size = EW'(esz + 1); r2 = r2 ^ 32'h5;
        to = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (done_p) begin
                to = 1'b0;
                break;
            end
            start_p = (c == repulse_at);
            @(negedge clk);
        end
        chk("timeout", to, 0);
        if (repulse_at >= 0) begin
            start_p = 1'b1;
            @(negedge clk);
            start_p = 1'b0;
        end else begin
            @(negedge clk);
        end
        start_p = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_idle_after", busy, 0);
        yo = y;
        pulses = n_en - en0;
        dones = n_done - d0;
    endtask

    typedef struct {
        logic [NB-1:0] x, e;
        int            esz;
        logic [NB-1:0] md;
        int            msz;
        logic [NB-1:0] y;
        int            p_fast, p_ct;
    } vec_t;

    vec_t tv[5];

    initial begin
        logic [NB-1:0] yo, md, x, e;
        int pulses, dones, esz, msz, p_exp, en_snap, d_snap;
        bit to;

        #2_000_000;
        $display("FAIL watchdog actual=%0d required=%0d", 1, 0);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] yo, md, x, e;
        int pulses, dones, esz, msz, p_exp, en_snap, d_snap;
        bit to;

        tv[0] = '{x:5792, e:3,             esz:2, md:72639, msz:17, y:60038, p_fast:7, p_ct:7};
        tv[1] = '{x:5792, e:4,             esz:3, md:72639, msz:17, y:17203, p_fast:7, p_ct:9};
        tv[2] = '{x:5792, e:32'hFFFF_FFF3, esz:2, md:72639, msz:17, y:60038, p_fast:7, p_ct:7};
        tv[3] = '{x:5792, e:7,             esz:0, md:72639, msz:17, y:1,     p_fast:3, p_ct:3};
        tv[4] = '{x:5792, e:1,             esz:1, md:72639, msz:17, y:5792,  p_fast:5, p_ct:5};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_p, 0);
        chk("rst_en", mm_enable_p, 0);
        chk("rst_y", y, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_b", mm_b, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_op(tv[i].x, tv[i].e, tv[i].esz, tv[i].md, tv[i].msz, -1, yo, pulses, dones);
`ifdef MODEXP_CONST_TIME_EN
            p_exp = tv[i].p_ct;
`else
            p_exp = tv[i].p_fast;
`endif
            chk("vec_y", yo, tv[i].y);
            chk("vec_pulses", pulses, p_exp);
            chk("vec_dones", dones, 1);
        end

        for (int i = 0; i < 6; i++) begin
            msz = $urandom_range(4, 20);
            md = ($urandom & ((32'd1 << msz) - 1)) | (32'd1 << (msz - 1)) | 32'd1;
            x = $urandom % md;
            e = $urandom;
            esz = (i == 0) ? 40 : $urandom_range(0, 34);
            run_op(x, e, esz, md, msz, -1, yo, pulses, dones);
            chk("rand_y", yo, ref_pow(x, e, esz, md));
            chk("rand_pulses", pulses, ref_pulses(e, esz));
            chk("rand_dones", dones, 1);
        end

        // start_p re-pulsed mid-run and in the DONE cycle
        run_op(tv[0].x, tv[0].e, tv[0].esz, tv[0].md, tv[0].msz, 30, yo, pulses, dones);
        chk("repulse_y", yo, 60038);
        chk("repulse_pulses", pulses, 7);
        chk("repulse_dones", dones, 1);

        // reset while squaring, then a stray multiplier completion
        @(negedge clk);
        base = 5792; exp = 32'hFF; e_size = EW'(8); m = 72639; m_size = 11'd17; r2 = r2_of(72639, 17);
        en_snap = n_en;
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (n_en - en_snap >= 3) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("sqr_reach_timeout", to, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_y", y, 0);
        en_snap = n_en;
        d_snap = n_done;
        stray_req++;
        repeat (20) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_no_done", n_done - d_snap, 0);
        chk("stray_no_en", n_en - en_snap, 0);
        run_op(tv[1].x, tv[1].e, tv[1].esz, tv[1].md, tv[1].msz, -1, yo, pulses, dones);
`ifdef MODEXP_CONST_TIME_EN
        p_exp = tv[1].p_ct;
`else
        p_exp = tv[1].p_fast;
`endif
        chk("post_rst_y", yo, 17203);
        chk("post_rst_pulses", pulses, p_exp);
        chk("post_rst_dones", dones, 1);

        chk("operand_stability", stab_bad, 0);
        chk("busy_low_in_done", busy_in_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
